// File: rtl/cdb_arbiter_pkg.sv
// Shared sizing and types for the CDB arbiter: ROB index width, the buffered
// {rob_entry,value} record, and the source identifiers used by the round-robin pointer.
package cdb_arbiter_pkg;

    localparam int ROB_SIZE = 16;
    localparam int ROB_BIT  = $clog2(ROB_SIZE);
    localparam int VALUE_W  = 32;

    typedef logic [ROB_BIT-1:0] rob_idx_t;

    typedef struct packed {
        rob_idx_t           rob_entry;
        logic [VALUE_W-1:0] value;
    } cdb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-source handshake (valid/ready with ROB tag and value) and the
// single-cycle CDB broadcast bus.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic               valid;
    rob_idx_t           rob_entry;
    logic [VALUE_W-1:0] value;
    logic               ready;

    modport master (output valid, rob_entry, value, input ready);
    modport slave  (input valid, rob_entry, value, output ready);
endinterface

interface cdb_bcast_if;
    import cdb_arbiter_pkg::*;

    logic               valid;
    rob_idx_t           rob_entry;
    logic [VALUE_W-1:0] value;

    modport master (output valid, rob_entry, value);
    modport slave  (input valid, rob_entry, value);
endinterface

// File: rtl/cdb_arbiter_fifo.sv
// Per-source holding FIFO: write visible at head one edge after push; no internal
// backpressure, the owner must not push when full or pop when empty.
module cdb_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_dat
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter over ALU/LSB FIFOs, 2-cycle push-to-broadcast latency, rdy_in low
// freezes all state and src_ready drops when a FIFO is full. CDB_PERF_EN adds conflict_cnt.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          clear_up,
    cdb_arbiter_if.slave  alu,
    cdb_arbiter_if.slave  lsb,
    cdb_bcast_if.master   cdb
`ifdef CDB_PERF_EN
    ,
    output logic [31:0]   conflict_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic       active;
    logic       flush;
    logic [CW-1:0] alu_cnt, lsb_cnt;
    cdb_entry_t alu_head, lsb_head;
    logic       alu_push, lsb_push;
    logic       alu_ne, lsb_ne;
    logic       grant_alu, grant_lsb;
    logic       pop_alu, pop_lsb;
    src_e       last_q, last_d;

    logic               cdb_vld_q;
    rob_idx_t           cdb_rob_q;
    logic [VALUE_W-1:0] cdb_val_q;

    assign active = rdy_in && !clear_up;
    assign flush  = rdy_in && clear_up;

    // Ready ignores a same-cycle pop; rst_in gating keeps it low during reset.
    assign alu.ready = rst_in && rdy_in && (alu_cnt < CW'(FIFO_DEPTH));
    assign lsb.ready = rst_in && rdy_in && (lsb_cnt < CW'(FIFO_DEPTH));

    assign alu_push = active && alu.valid && alu.ready;
    assign lsb_push = active && lsb.valid && lsb.ready;

    assign alu_ne = (alu_cnt != '0);
    assign lsb_ne = (lsb_cnt != '0);

    assign pop_alu = active && grant_alu;
    assign pop_lsb = active && grant_lsb;

    cdb_fifo #(.WIDTH($bits(cdb_entry_t)), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk      (clk_in),
        .rst_n    (rst_in),
        .push     (alu_push),
        .push_dat ({alu.rob_entry, alu.value}),
        .pop      (pop_alu),
        .flush    (flush),
        .count    (alu_cnt),
        .head_dat (alu_head)
    );

    cdb_fifo #(.WIDTH($bits(cdb_entry_t)), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk      (clk_in),
        .rst_n    (rst_in),
        .push     (lsb_push),
        .push_dat ({lsb.rob_entry, lsb.value}),
        .pop      (pop_lsb),
        .flush    (flush),
        .count    (lsb_cnt),
        .head_dat (lsb_head)
    );

    // Last-grant pointer starts at LSB so the first conflict goes to the ALU.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) last_q <= SRC_LSB;
        else         last_q <= last_d;
    end

    always_comb begin
        last_d = last_q;
        if (flush)        last_d = SRC_ALU;
        else if (pop_alu) last_d = SRC_ALU;
        else if (pop_lsb) last_d = SRC_LSB;
    end

    always_comb begin
        grant_alu = 1'b0;
        grant_lsb = 1'b0;
        if (alu_ne && lsb_ne) begin
            if (last_q == SRC_LSB) grant_alu = 1'b1;
            else                   grant_lsb = 1'b1;
        end else if (alu_ne) begin
            grant_alu = 1'b1;
        end else if (lsb_ne) begin
            grant_lsb = 1'b1;
        end
    end

    // Data registers only move on a grant so a paused or idle bus keeps its last value.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cdb_vld_q <= 1'b0;
            cdb_rob_q <= '0;
            cdb_val_q <= '0;
        end else if (rdy_in) begin
            if (clear_up) begin
                cdb_vld_q <= 1'b0;
            end else if (pop_alu) begin
                cdb_vld_q <= 1'b1;
                cdb_rob_q <= alu_head.rob_entry;
                cdb_val_q <= alu_head.value;
            end else if (pop_lsb) begin
                cdb_vld_q <= 1'b1;
                cdb_rob_q <= lsb_head.rob_entry;
                cdb_val_q <= lsb_head.value;
            end else begin
                cdb_vld_q <= 1'b0;
            end
        end
    end

    assign cdb.valid     = cdb_vld_q;
    assign cdb.rob_entry = cdb_rob_q;
    assign cdb.value     = cdb_val_q;

`ifdef CDB_PERF_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            conflict_cnt <= '0;
        end else if (active && alu_ne && lsb_ne && (conflict_cnt != 32'hFFFF_FFFF)) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Table-driven bench for cdb_arbiter with per-source scoreboards plus hand-written
// sequences for single-push latency, conflict, pause, flush and async reset.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NONE = 0;
    localparam int ALU  = 1;
    localparam int LSB  = 2;
    localparam int HOLD = 3;
    localparam int NV   = 28;

    logic clk_in   = 1'b0;
    logic rst_in   = 1'b0;
    logic rdy_in   = 1'b0;
    logic clear_up = 1'b0;

    always #5 clk_in = ~clk_in;

    cdb_arbiter_if alu_if ();
    cdb_arbiter_if lsb_if ();
    cdb_bcast_if   cdb_if ();
`ifdef CDB_PERF_EN
    logic [31:0] conflict_cnt;
`endif

    cdb_arbiter #(.FIFO_DEPTH(2)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .clear_up (clear_up),
        .alu      (alu_if),
        .lsb      (lsb_if),
        .cdb      (cdb_if)
`ifdef CDB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    typedef struct {
        logic       rdy, clr, av;
        logic [3:0] ae;
        logic       lv;
        logic [3:0] le;
        logic       ar, lr;
        int         cs;
    } vec_t;

    vec_t       tbl [NV];
    cdb_entry_t alu_q [$];
    cdb_entry_t lsb_q [$];
    cdb_entry_t last_exp;
    cdb_entry_t got;
    int n_vec = 0;
    int n_bad = 0;

    function automatic vec_t mk(input logic rdy, input logic clr, input logic av, input int ae,
                                input logic lv, input int le, input logic ar, input logic lr,
                                input int cs);
        vec_t v;
        v.rdy = rdy; v.clr = clr; v.av = av; v.ae = 4'(ae);
        v.lv = lv;   v.le = 4'(le); v.ar = ar; v.lr = lr; v.cs = cs;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        alu_if.valid = 1'b0; alu_if.rob_entry = '0; alu_if.value = '0;
        lsb_if.valid = 1'b0; lsb_if.rob_entry = '0; lsb_if.value = '0;
        clear_up = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        drive_idle();
        rdy_in = 1'b1;
        rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst cdb_valid", 32'(cdb_if.valid), 32'd0);
        check("rst cdb_rob_entry", 32'(cdb_if.rob_entry), 32'd0);
        check("rst cdb_value", cdb_if.value, 32'd0);
        check("rst alu_ready", 32'(alu_if.ready), 32'd0);
        check("rst lsb_ready", 32'(lsb_if.ready), 32'd0);
`ifdef CDB_PERF_EN
        check("rst conflict_cnt", conflict_cnt, 32'd0);
`endif
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(1,0, 1, 1, 1, 2,  1,1, NONE);
        tbl[1]  = mk(1,0, 0, 0, 0, 0,  1,1, ALU);
        tbl[2]  = mk(1,0, 0, 0, 0, 0,  1,1, LSB);
        tbl[3]  = mk(1,0, 0, 0, 0, 0,  1,1, NONE);
        tbl[4]  = mk(1,0, 1, 3, 1, 8,  1,1, NONE);
        tbl[5]  = mk(1,0, 1, 4, 1, 9,  1,1, ALU);
        tbl[6]  = mk(1,0, 1, 5, 1,10,  1,0, LSB);
        tbl[7]  = mk(1,0, 1, 6, 1,10,  0,1, ALU);
        tbl[8]  = mk(1,0, 1, 6, 1,11,  1,0, LSB);
        tbl[9]  = mk(1,0, 1, 7, 1,11,  0,1, ALU);
        tbl[10] = mk(1,0, 1, 7, 1,12,  1,0, LSB);
        tbl[11] = mk(1,0, 0, 0, 0, 0,  0,1, ALU);
        tbl[12] = mk(1,0, 0, 0, 0, 0,  1,1, LSB);
        tbl[13] = mk(1,0, 0, 0, 0, 0,  1,1, ALU);
        tbl[14] = mk(1,0, 0, 0, 0, 0,  1,1, NONE);
        tbl[15] = mk(1,0, 1, 7, 0, 0,  1,1, NONE);
        tbl[16] = mk(1,0, 1,13, 1,12,  1,1, ALU);
        tbl[17] = mk(0,0, 1,14, 1,14,  0,0, HOLD);
        tbl[18] = mk(0,1, 1,14, 1,14,  0,0, HOLD);
        tbl[19] = mk(0,0, 1,14, 1,14,  0,0, HOLD);
        tbl[20] = mk(1,0, 0, 0, 0, 0,  1,1, LSB);
        tbl[21] = mk(1,0, 0, 0, 0, 0,  1,1, ALU);
        tbl[22] = mk(1,0, 0, 0, 0, 0,  1,1, NONE);
        tbl[23] = mk(1,0, 1, 1, 1, 2,  1,1, NONE);
        tbl[24] = mk(1,0, 1, 3, 1, 4,  1,1, LSB);
        tbl[25] = mk(1,1, 1, 9, 1, 9,  0,1, NONE);
        tbl[26] = mk(1,0, 0, 0, 0, 0,  1,1, NONE);
        tbl[27] = mk(1,0, 0, 0, 0, 0,  1,1, NONE);

        drive_idle();
        do_reset();

        // Single uncontended push: broadcast one edge after acceptance, then idle with data held.
        @(negedge clk_in);
        alu_if.valid = 1'b1; alu_if.rob_entry = 4'd3; alu_if.value = 32'h1234;
        #1;
        check("single alu_ready", 32'(alu_if.ready), 32'd1);
        @(posedge clk_in); #1;
        check("single cdb_valid@E", 32'(cdb_if.valid), 32'd0);
        @(negedge clk_in);
        drive_idle();
        @(posedge clk_in); #1;
        check("single cdb_valid@E+1", 32'(cdb_if.valid), 32'd1);
        check("single cdb_rob_entry", 32'(cdb_if.rob_entry), 32'd3);
        check("single cdb_value", cdb_if.value, 32'h1234);
        @(posedge clk_in); #1;
        check("single cdb_valid@E+2", 32'(cdb_if.valid), 32'd0);
        check("single data held", cdb_if.value, 32'h1234);

        do_reset();

        for (int i = 0; i < NV; i++) begin
            @(negedge clk_in);
            rdy_in   = tbl[i].rdy;
            clear_up = tbl[i].clr;
            alu_if.valid = tbl[i].av; alu_if.rob_entry = tbl[i].ae;
            alu_if.value = 32'hA000_0000 + 32'(i);
            lsb_if.valid = tbl[i].lv; lsb_if.rob_entry = tbl[i].le;
            lsb_if.value = 32'hB000_0000 + 32'(i);
            #1;
            check($sformatf("v%0d alu_ready", i), 32'(alu_if.ready), 32'(tbl[i].ar));
            check($sformatf("v%0d lsb_ready", i), 32'(lsb_if.ready), 32'(tbl[i].lr));
            if (tbl[i].rdy && !tbl[i].clr && tbl[i].av && tbl[i].ar)
                alu_q.push_back('{tbl[i].ae, 32'hA000_0000 + 32'(i)});
            if (tbl[i].rdy && !tbl[i].clr && tbl[i].lv && tbl[i].lr)
                lsb_q.push_back('{tbl[i].le, 32'hB000_0000 + 32'(i)});
            if (tbl[i].rdy && tbl[i].clr) begin
                alu_q.delete();
                lsb_q.delete();
            end
            @(posedge clk_in); #1;
            got = '{cdb_if.rob_entry, cdb_if.value};
            if (tbl[i].cs == NONE) begin
                check($sformatf("v%0d cdb_valid", i), 32'(cdb_if.valid), 32'd0);
            end else if (tbl[i].cs == HOLD) begin
                check($sformatf("v%0d held cdb_valid", i), 32'(cdb_if.valid), 32'd1);
                check($sformatf("v%0d held rob_entry", i), 32'(got.rob_entry), 32'(last_exp.rob_entry));
                check($sformatf("v%0d held value", i), got.value, last_exp.value);
            end else begin
                check($sformatf("v%0d cdb_valid", i), 32'(cdb_if.valid), 32'd1);
                if ((tbl[i].cs == ALU && alu_q.size() == 0) ||
                    (tbl[i].cs == LSB && lsb_q.size() == 0)) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL v%0d scoreboard: got broadcast 0x%0h, wanted none queued", i, got.value);
                end else begin
                    last_exp = (tbl[i].cs == ALU) ? alu_q.pop_front() : lsb_q.pop_front();
                    check($sformatf("v%0d rob_entry", i), 32'(got.rob_entry), 32'(last_exp.rob_entry));
                    check($sformatf("v%0d value", i), got.value, last_exp.value);
                end
            end
`ifdef CDB_PERF_EN
            if (i == 1) check("conflict_cnt after first conflict", conflict_cnt, 32'd1);
`endif
        end

        // Asynchronous reset between edges clears outputs immediately and drops buffered work.
        @(negedge clk_in);
        rdy_in = 1'b1;
        alu_if.valid = 1'b1; alu_if.rob_entry = 4'd5; alu_if.value = 32'hC0DE_0005;
        lsb_if.valid = 1'b1; lsb_if.rob_entry = 4'd6; lsb_if.value = 32'hC0DE_0006;
        @(negedge clk_in);
        drive_idle();
        @(posedge clk_in); #1;
        check("midrst cdb_valid before", 32'(cdb_if.valid), 32'd1);
        #2;
        rst_in = 1'b0;
        #1;
        check("midrst cdb_valid", 32'(cdb_if.valid), 32'd0);
        check("midrst cdb_rob_entry", 32'(cdb_if.rob_entry), 32'd0);
        check("midrst cdb_value", cdb_if.value, 32'd0);
        check("midrst alu_ready", 32'(alu_if.ready), 32'd0);
        check("midrst lsb_ready", 32'(lsb_if.ready), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_in); #1;
            check($sformatf("postrst idle %0d cdb_valid", k), 32'(cdb_if.valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
